// File: rtl/hid_keycode_if.sv
// Avalon-MM register bus plus the key-event valid/ready stream of hid_keycode_pio.
interface hid_keycode_if #(
  parameter int unsigned KEY_W = 8
);
  logic [2:0]     address;
  logic           chipselect;
  logic           write_n;
  logic [31:0]    writedata;
  logic [31:0]    readdata;
  logic           ev_valid;
  logic [KEY_W:0] ev_data;
  logic           ev_ready;

  modport slave (
    input  address, chipselect, write_n, writedata, ev_ready,
    output readdata, ev_valid, ev_data
  );

  modport master (
    output address, chipselect, write_n, writedata, ev_ready,
    input  readdata, ev_valid, ev_data
  );
endinterface

// File: rtl/hid_keycode_pio.sv
// Keyboard-report port: staged keycodes committed atomically, with a press/release
// diff scan that feeds a show-ahead event FIFO.
module hid_keycode_pio #(
  parameter int unsigned KEY_W      = 8,
  parameter int unsigned NUM_KEYS   = 6,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  hid_keycode_if.slave              bus,
  output logic [NUM_KEYS*KEY_W-1:0] out_port,
  output logic                      any_key
);

  localparam int unsigned IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned EV_W  = KEY_W + 1;

  typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [KEY_W-1:0] stage     [NUM_KEYS];
  logic [KEY_W-1:0] committed [NUM_KEYS];
  logic [KEY_W-1:0] prev      [NUM_KEYS];
  logic [EV_W-1:0]  mem       [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             overflow, commit_drop;

  logic             wr, commit_wr, status_wr, busy;
  logic             push, push_ok, pop, full, hit;
  logic [EV_W-1:0]  push_data;
  logic [31:0]      rd;
  logic             unused_bits;

  assign wr          = bus.chipselect && !bus.write_n;
  assign commit_wr   = wr && (bus.address == 3'd7);
  assign status_wr   = wr && (bus.address == 3'd6);
  assign busy        = (state_q != IDLE);
  assign unused_bits = ^bus.writedata;

  // Scan engine: one slot per cycle, presses first, then releases
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    push      = 1'b0;
    push_data = '0;
    hit       = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_wr) begin
          state_d = PRESS;
          idx_d   = '0;
        end
      end
      PRESS: begin
        for (int j = 0; j < NUM_KEYS; j++)
          if (prev[j] == committed[idx_q]) hit = 1'b1;
        if ((committed[idx_q] != '0) && !hit) begin
          push      = 1'b1;
          push_data = {1'b1, committed[idx_q]};
        end
        if (idx_q == IDX_W'(NUM_KEYS - 1)) begin
          state_d = RELEASE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RELEASE: begin
        for (int j = 0; j < NUM_KEYS; j++)
          if (committed[j] == prev[idx_q]) hit = 1'b1;
        if ((prev[idx_q] != '0) && !hit) begin
          push      = 1'b1;
          push_data = {1'b0, prev[idx_q]};
        end
        if (idx_q == IDX_W'(NUM_KEYS - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Staging and commit registers; commit snapshots stage and shifts old set to prev
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        stage[i]     <= '0;
        committed[i] <= '0;
        prev[i]      <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++)
        if (wr && (bus.address == 3'(i))) stage[i] <= bus.writedata[KEY_W-1:0];
      if (commit_wr && !busy) begin
        for (int i = 0; i < NUM_KEYS; i++) begin
          committed[i] <= stage[i];
          prev[i]      <= committed[i];
        end
      end
    end
  end

  // Event FIFO; a full FIFO still accepts a push when the head pops the same cycle
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop     = (count_q != '0) && bus.ev_ready;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow    <= 1'b0;
      commit_drop <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push && !push_ok)                     overflow <= 1'b1;
      else if (status_wr && bus.writedata[8])   overflow <= 1'b0;
      if (commit_wr && busy)                    commit_drop <= 1'b1;
      else if (status_wr && bus.writedata[10])  commit_drop <= 1'b0;
    end
  end

  assign bus.ev_valid = (count_q != '0);
  assign bus.ev_data  = bus.ev_valid ? mem[rd_ptr] : '0;

  // Zero-latency register readback
  always_comb begin
    rd = '0;
    case (bus.address)
      3'd6: begin
        rd[CNT_W-1:0] = count_q;
        rd[8]         = overflow;
        rd[9]         = busy;
        rd[10]        = commit_drop;
      end
      default: begin
        for (int i = 0; i < NUM_KEYS; i++)
          if (bus.address == 3'(i)) rd = 32'(stage[i]);
      end
    endcase
  end

  assign bus.readdata = rd;

  always_comb begin
    out_port = '0;
    for (int i = 0; i < NUM_KEYS; i++) out_port[i*KEY_W +: KEY_W] = committed[i];
  end

  assign any_key = |out_port;

endmodule

// File: tb/tb_hid_keycode_pio.sv
// Directed bench for hid_keycode_pio with hand-computed expectations (KEY_W=8, NUM_KEYS=6, FIFO_DEPTH=8).
module tb_hid_keycode_pio;

  logic        clk;
  logic        reset;
  logic [47:0] out_port;
  logic        any_key;
  int          n_assert = 0;
  int          n_fail   = 0;

  hid_keycode_if #(.KEY_W(8)) bus ();

  hid_keycode_pio #(.KEY_W(8), .NUM_KEYS(6), .FIFO_DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .out_port (out_port),
    .any_key  (any_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    cyc();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic pop_one();
    bus.ev_ready = 1'b1;
    cyc();
    bus.ev_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] d;
    int          n;
    n = 0;
    bus_rd(3'd6, d);
    while (d[9] && n < 100) begin
      cyc();
      n++;
      bus_rd(3'd6, d);
    end
    check(tag, 64'(d[9]), 64'd0);
  endtask

  initial begin
    logic [31:0] d;
    int          n;
    logic [8:0]  drain_exp [8];

    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    bus.ev_ready   = 1'b0;
    reset          = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    // Reset state
    for (int a = 0; a < 8; a++) begin
      cyc();
      bus_rd(3'(a), d);
      check($sformatf("reset_read_%0d", a), 64'(d), 64'd0);
    end
    check("reset_out_port", 64'(out_port), 64'd0);
    check("reset_any_key", 64'(any_key), 64'd0);
    check("reset_ev_valid", 64'(bus.ev_valid), 64'd0);
    check("reset_ev_data", 64'(bus.ev_data), 64'd0);

    // Two presses
    bus_wr(3'd0, 32'h0000_0004);
    bus_wr(3'd1, 32'hFFFF_FF1A);
    bus_rd(3'd0, d);
    check("stage0_readback", 64'(d), 64'h04);
    cyc();
    bus_rd(3'd1, d);
    check("stage1_readback", 64'(d), 64'h1A);
    cyc();
    bus_wr(3'd7, 32'h0);
    check("commit1_out_port", 64'(out_port), 64'h1A04);
    check("commit1_any_key", 64'(any_key), 64'd1);
    bus_rd(3'd6, d);
    check("commit1_status_T", 64'(d), 64'h200);
    cyc();
    check("commit1_first_valid", 64'(bus.ev_valid), 64'd1);
    check("commit1_first_data", 64'(bus.ev_data), 64'h104);
    n = 1;
    bus_rd(3'd6, d);
    while (d[9] && n < 40) begin
      cyc();
      n++;
      bus_rd(3'd6, d);
    end
    check("commit1_busy_cycles", 64'(n), 64'd12);
    check("commit1_status_idle", 64'(d), 64'h002);
    check("commit1_head0", 64'(bus.ev_data), 64'h104);
    pop_one();
    check("commit1_head1", 64'(bus.ev_data), 64'h11A);
    pop_one();
    check("commit1_drained", 64'(bus.ev_valid), 64'd0);

    // Single release of 0x04
    bus_wr(3'd0, 32'h0);
    bus_wr(3'd7, 32'h0);
    check("commit2_out_port", 64'(out_port), 64'h1A00);
    wait_idle("commit2_idle");
    bus_rd(3'd6, d);
    check("commit2_count", 64'(d), 64'h001);
    check("commit2_event", 64'(bus.ev_data), 64'h004);
    pop_one();
    check("commit2_drained", 64'(bus.ev_valid), 64'd0);

    // Fill: 6 presses + release of 0x1A, then 6 more presses overflow the FIFO
    for (int i = 0; i < 6; i++) bus_wr(3'(i), 32'(8'h21 + i));
    bus_wr(3'd7, 32'h0);
    wait_idle("fill1_idle");
    bus_rd(3'd6, d);
    check("fill1_status", 64'(d), 64'h007);
    cyc();
    for (int i = 0; i < 6; i++) bus_wr(3'(i), 32'(8'h31 + i));
    bus_wr(3'd7, 32'h0);
    wait_idle("fill2_idle");
    bus_rd(3'd6, d);
    check("overflow_status", 64'(d), 64'h108);
    check("overflow_head", 64'(bus.ev_data), 64'h121);
    cyc();
    bus_wr(3'd6, 32'h100);
    bus_rd(3'd6, d);
    check("overflow_cleared", 64'(d), 64'h008);

    // Commit while busy, and push+pop while full
    cyc();
    bus_wr(3'd0, 32'h41);
    bus_wr(3'd7, 32'h0);
    bus.ev_ready = 1'b1;
    bus_wr(3'd7, 32'h0);
    bus.ev_ready = 1'b0;
    bus_rd(3'd6, d);
    check("drop_status", 64'(d), 64'h608);
    check("drop_out_port", 64'(out_port), 64'h3635_3433_3241);
    check("full_pushpop_head", 64'(bus.ev_data), 64'h122);
    wait_idle("drop_idle");
    bus_rd(3'd6, d);
    check("drop_overflow_again", 64'(d), 64'h508);
    cyc();
    bus_wr(3'd6, 32'h400);
    bus_rd(3'd6, d);
    check("commit_drop_cleared", 64'(d), 64'h108);
    cyc();
    bus_wr(3'd6, 32'h100);

    drain_exp = '{9'h122, 9'h123, 9'h124, 9'h125, 9'h126, 9'h01A, 9'h131, 9'h141};
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_valid_%0d", i), 64'(bus.ev_valid), 64'd1);
      check($sformatf("drain_data_%0d", i), 64'(bus.ev_data), 64'(drain_exp[i]));
      pop_one();
    end
    check("drain_empty", 64'(bus.ev_valid), 64'd0);

    // Reset mid-scan
    for (int i = 0; i < 6; i++) bus_wr(3'(i), 32'(8'h51 + i));
    bus_wr(3'd7, 32'h0);
    cyc();
    cyc();
    bus_rd(3'd6, d);
    check("midscan_status", 64'(d), 64'h202);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("midscan_ev_valid", 64'(bus.ev_valid), 64'd0);
    check("midscan_ev_data", 64'(bus.ev_data), 64'd0);
    check("midscan_out_port", 64'(out_port), 64'd0);
    check("midscan_any_key", 64'(any_key), 64'd0);
    bus_rd(3'd6, d);
    check("midscan_status_reset", 64'(d), 64'd0);
    repeat (5) cyc();
    check("midscan_no_push", 64'(bus.ev_valid), 64'd0);
    bus_rd(3'd0, d);
    check("midscan_stage_cleared", 64'(d), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
